// File: rtl/fb_hazard_ctl.sv
// Firebird hazard controller: load-use/RAW stalls, redirect flushes, fetch waits, dmem freezes.
// Define FB_FORWARD_EN when EX/MEM->EX forwarding exists (only load-use stalls remain).
`timescale 1ns/1ps
module fb_hazard_ctl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_we,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_lock,
  output logic             ifid_rst,
  output logic             idex_lock,
  output logic             idex_rst,
  output logic             exmem_lock,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DWAIT = 2'd2
  } state_e;

  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);

  state_e           state_q, state_d, eff;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             hazard;

  function automatic logic dep(input logic [4:0] x);
    return (x != 5'd0) &&
           ((id_rs1_used && id_rs1 == x) ||
            (id_rs2_used && id_rs2 == x));
  endfunction

`ifdef FB_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_reg_we};
  assign hazard = ex_reg_we && ex_is_load && dep(ex_rd);
`else
  assign hazard = (ex_reg_we && dep(ex_rd)) ||
                  (mem_reg_we && dep(mem_rd));
`endif

  // The flush counter holds during a freeze, so it alone tells which state to resume.
  always_comb begin
    eff = state_q;
    if (state_q == DWAIT)
      eff = (fcnt_q != 2'd0) ? FLUSH : RUN;
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_lock  = 1'b0;
    ifid_rst   = 1'b0;
    idex_lock  = 1'b0;
    idex_rst   = 1'b0;
    exmem_lock = 1'b0;
    state_d    = eff;
    fcnt_d     = fcnt_q;
    if (dmem_busy) begin
      pc_we      = 1'b0;
      ifid_lock  = 1'b1;
      idex_lock  = 1'b1;
      exmem_lock = 1'b1;
      state_d    = DWAIT;
    end else if (ex_redirect) begin
      ifid_rst = 1'b1;
      idex_rst = 1'b1;
      fcnt_d   = FC;
      state_d  = (FC != 2'd0) ? FLUSH : RUN;
    end else if (eff == FLUSH) begin
      ifid_rst = 1'b1;
      if (fcnt_q <= 2'd1) begin
        fcnt_d  = 2'd0;
        state_d = RUN;
      end else begin
        fcnt_d  = fcnt_q - 2'd1;
        state_d = FLUSH;
      end
    end else if (hazard) begin
      pc_we     = 1'b0;
      ifid_lock = 1'b1;
      idex_rst  = 1'b1;
    end else if (!imem_ready) begin
      pc_we    = 1'b0;
      ifid_rst = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_we && stall_q != {CNT_W{1'b1}})
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fb_hazard_ctl.sv
// Self-checking bench for fb_hazard_ctl against a cycle-level reference model.
`timescale 1ns/1ps
module tb_fb_hazard_ctl;

  localparam int FC = 2;

  typedef struct {
    bit busy, redir, imem;
    bit [4:0] rs1, rs2;
    bit u1, u2;
    bit [4:0] exrd;
    bit exwe, exld;
    bit [4:0] memrd;
    bit memwe;
  } stim_t;

  logic clk = 0, rst = 1;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_rs1_used, id_rs2_used, ex_reg_we, ex_is_load, mem_reg_we;
  logic ex_redirect, imem_ready, dmem_busy;
  logic pc_we, ifid_we, ifid_lock, ifid_rst, idex_lock, idex_rst, exmem_lock;
  logic [1:0] state;
  logic [15:0] stall_cnt;

  int n_tests = 0, n_fail = 0;

  // model: mode 0=run 1=flush 2=frozen; resume = mode to return to after a freeze
  int m_mode, m_resume, m_left, m_stalls;
  int n_mode, n_resume, n_left, n_stalls;
  logic [24:0] exp_v;
  wire  [24:0] act_v = {pc_we, ifid_we, ifid_lock, ifid_rst, idex_lock,
                        idex_rst, exmem_lock, state, stall_cnt};

  fb_hazard_ctl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_lock(ifid_lock),
    .ifid_rst(ifid_rst), .idex_lock(idex_lock), .idex_rst(idex_rst),
    .exmem_lock(exmem_lock), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.imem = 1;
    return s;
  endfunction

  function automatic bit reads(stim_t s, bit [4:0] x);
    return x != 0 && ((s.u1 && s.rs1 == x) || (s.u2 && s.rs2 == x));
  endfunction

  function automatic bit depends(stim_t s);
`ifdef FB_FORWARD_EN
    return s.exwe && s.exld && reads(s, s.exrd);
`else
    return (s.exwe && reads(s, s.exrd)) || (s.memwe && reads(s, s.memrd));
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_resume = 0; m_left = 0; m_stalls = 0;
  endtask

  // apply inputs, settle, and form this cycle's expected outputs and next model state
  task automatic drive(input stim_t s);
    bit pw, il, ir, xl, xr, ml;
    int cur;
    id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2;
    ex_rd = s.exrd; ex_reg_we = s.exwe; ex_is_load = s.exld;
    mem_rd = s.memrd; mem_reg_we = s.memwe;
    ex_redirect = s.redir; imem_ready = s.imem; dmem_busy = s.busy;
    #1;
    pw = 1; il = 0; ir = 0; xl = 0; xr = 0; ml = 0;
    cur = (m_mode == 2) ? m_resume : m_mode;
    n_mode = cur; n_resume = m_resume; n_left = m_left;
    if (s.busy) begin
      pw = 0; il = 1; xl = 1; ml = 1;
      if (m_mode != 2) n_resume = m_mode;
      n_mode = 2;
    end else if (s.redir) begin
      ir = 1; xr = 1;
      n_left = FC;
      n_mode = (FC > 0) ? 1 : 0;
    end else if (cur == 1) begin
      ir = 1;
      n_left = m_left - 1;
      n_mode = (n_left <= 0) ? 0 : 1;
      if (n_left < 0) n_left = 0;
    end else if (depends(s)) begin
      pw = 0; il = 1; xr = 1;
    end else if (!s.imem) begin
      pw = 0; ir = 1;
    end
    n_stalls = (!pw && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
    exp_v = {pw, 1'b1, il, ir, xl, xr, ml, 2'(m_mode), 16'(m_stalls)};
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_mode = n_mode; m_resume = n_resume;
      m_left = n_left; m_stalls = n_stalls;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(idle());
      n_tests++;
      if (act_v !== {7'b1100000, 18'd0}) begin
        n_fail++;
        $display("FAIL reset cyc%0d act=%h exp=%h", i, act_v, {7'b1100000, 18'd0});
      end
      step();
    end
    rst = 0;
  endtask

  task automatic test_load_use(input bit [4:0] rd);
    stim_t s[3];
    int base, want;
    s[0] = idle(); s[1] = idle(); s[2] = idle();
    s[0].exwe = 1; s[0].exrd = rd;
    s[1].memwe = 1; s[1].memrd = rd;
`ifdef FB_FORWARD_EN
    s[0].exld = 1;
    for (int i = 0; i < 3; i++) begin s[i].rs1 = rd; s[i].u1 = 1; end
    want = (rd != 0) ? 1 : 0;
`else
    for (int i = 0; i < 3; i++) begin s[i].rs2 = rd; s[i].u2 = 1; end
    want = (rd != 0) ? 2 : 0;
`endif
    base = int'(stall_cnt);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL load_use rd%0d cyc%0d act=%h exp=%h", rd, i, act_v, exp_v);
      end
      step();
    end
    n_tests++;
    if (int'(stall_cnt) - base != want) begin
      n_fail++;
      $display("FAIL load_use_cnt rd%0d act=%0d exp=%0d", rd, int'(stall_cnt) - base, want);
    end
  endtask

  task automatic test_redirect();
    stim_t s;
    int exp_st[4] = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      s = idle();
      s.redir = (i == 0);
      drive(s);
      n_tests++;
      if (act_v !== exp_v || int'(state) != exp_st[i]) begin
        n_fail++;
        $display("FAIL redirect cyc%0d act=%h exp=%h st_exp=%0d", i, act_v, exp_v, exp_st[i]);
      end
      step();
    end
  endtask

  task automatic test_freeze_mid_flush();
    stim_t s;
    for (int i = 0; i < 7; i++) begin
      s = idle();
      s.redir = (i == 0);
      s.busy = (i >= 2 && i <= 4);
      drive(s);
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL freeze_flush cyc%0d act=%h exp=%h", i, act_v, exp_v);
      end
      if (i >= 3 && i <= 5 && state !== 2'd2) begin
        n_fail++;
        $display("FAIL freeze_state cyc%0d act=%0d exp=2", i, state);
      end
      if (i == 5 && ifid_rst !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_resume act=%b exp=1", ifid_rst);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 6; i++) begin
      s = idle();
      if (i == 0) begin
        s.redir = 1; s.exwe = 1; s.exld = 1; s.exrd = 9; s.rs1 = 9; s.u1 = 1;
      end
      s.imem = !(i == 3 || i == 4);
      drive(s);
      n_tests++;
      if (act_v !== exp_v || pc_we !== !(i == 3 || i == 4)) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d act=%h exp=%h", i, act_v, exp_v);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    s = idle();
    s.busy = 1;
    for (int i = 0; i < 2; i++) begin drive(s); step(); end
    n_tests++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL dwait_entry act=%0d exp=2", state);
    end
    #2 rst = 1;
    #1;
    n_tests++;
    if ({state, stall_cnt} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset act=%h exp=0", {state, stall_cnt});
    end
    model_reset();
    @(negedge clk);
    drive(idle());
    step();
    rst = 0;
  endtask

  task automatic test_random(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.busy = ($urandom_range(0, 5) == 0);
      s.redir = ($urandom_range(0, 7) == 0);
      s.imem = ($urandom_range(0, 4) != 0);
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom);
      s.exrd = 5'($urandom_range(0, 3)); s.exwe = 1'($urandom); s.exld = 1'($urandom);
      s.memrd = 5'($urandom_range(0, 3)); s.memwe = 1'($urandom);
      drive(s);
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc%0d act=%h exp=%h", i, act_v, exp_v);
      end
      step();
    end
  endtask

  task automatic test_saturate();
    stim_t s;
    s = idle();
    s.busy = 1;
    for (int i = 0; i < 70000; i++) begin drive(s); step(); end
    drive(idle());
    n_tests++;
    if (stall_cnt !== 16'hFFFF || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL saturate act=%h exp=%h", act_v, exp_v);
    end
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use(5'd7);
    test_load_use(5'd0);
    test_load_use(5'd5);
    test_redirect();
    test_freeze_mid_flush();
    test_back_to_back();
    test_async_reset();
    test_random(400);
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
